// File: rtl/divider_array_reconstructor_seq.sv
// Rebuilds a dividend from a divider result (q*d + r) with a shift-add multiplier,
// then scores it against the reference dividend and counts mismatches.
module divider_array_reconstructor_seq #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     q,
    input  logic [W-1:0]     r,
    input  logic [W-1:0]     d,
    input  logic [2*W-1:0]   n_ref,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   n_rec,
    output logic [2*W-1:0]   err,
    output logic             mismatch,
    output logic             dz,
    output logic [CNT_W-1:0] mism_cnt,
    input  logic             cnt_clr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_FIN,
        S_DONE
    } state_t;

    localparam int            IW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    state_t           r_state;
    state_t           w_state_next;

    logic [W-1:0]     r_q;
    logic [W-1:0]     r_d;
    logic [2*W-1:0]   r_nref;
    logic [2*W-1:0]   r_acc;
    logic [IW-1:0]    r_idx;
    logic [2*W-1:0]   r_n_rec;
    logic [2*W-1:0]   r_err;
    logic             r_mismatch;
    logic             r_dz;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_fin;
    logic [2*W-1:0]   w_partial;
    logic [2*W-1:0]   w_acc_next;
    logic [2*W-1:0]   w_err;
    logic             w_mism;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: defaulting every combinational output first prevents latch inference
    // on paths the case statement does not cover.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (in_valid)            w_state_next = S_MUL;
            S_MUL:  if (r_idx == LAST_IDX)   w_state_next = S_FIN;
            S_FIN:                           w_state_next = S_DONE;
            S_DONE: if (out_ready)           w_state_next = S_IDLE;
            default:                         w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_fin    = (r_state == S_FIN);

    // Partial product for bit i, formed in 2W bits; the product plus r never exceeds 2W bits.
    assign w_partial  = r_q[r_idx] ? ({{W{1'b0}}, r_d} << r_idx) : '0;
    assign w_acc_next = r_acc + w_partial;

    assign w_err  = (r_nref >= r_acc) ? (r_nref - r_acc) : (r_acc - r_nref);
    assign w_mism = (w_err != '0);

    // NOTE: every datapath register is reset, so an aborted request leaves no
    // stale operands or results behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q        <= '0;
            r_d        <= '0;
            r_nref     <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            r_n_rec    <= '0;
            r_err      <= '0;
            r_mismatch <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_q    <= q;
                r_d    <= d;
                r_nref <= n_ref;
                r_acc  <= {{W{1'b0}}, r};
                r_dz   <= (d == '0);
                r_idx  <= '0;
            end
            if (r_state == S_MUL) begin
                r_acc <= w_acc_next;
                r_idx <= r_idx + IW'(1);
            end
            if (w_fin) begin
                r_n_rec    <= r_acc;
                r_err      <= w_err;
                r_mismatch <= w_mism;
            end
        end
    end

    // Clear has priority over a same-edge increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_fin && w_mism && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign n_rec    = r_n_rec;
    assign err      = r_err;
    assign mismatch = r_mismatch;
    assign dz       = r_dz;
    assign mism_cnt = r_cnt;

endmodule

// File: tb/tb_divider_array_reconstructor_seq.sv
// Scoreboard bench for divider_array_reconstructor_seq: directed requests push
// hand-computed results; a monitor compares whenever out_valid is presented.
module tb_divider_array_reconstructor_seq;

    localparam int W     = 8;
    localparam int CNT_W = 2;
    localparam int LAT   = W + 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     q;
    logic [W-1:0]     r;
    logic [W-1:0]     d;
    logic [2*W-1:0]   n_ref;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   n_rec;
    logic [2*W-1:0]   err;
    logic             mismatch;
    logic             dz;
    logic [CNT_W-1:0] mism_cnt;
    logic             cnt_clr;

    divider_array_reconstructor_seq #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .r         (r),
        .d         (d),
        .n_ref     (n_ref),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n_rec     (n_rec),
        .err       (err),
        .mismatch  (mismatch),
        .dz        (dz),
        .mism_cnt  (mism_cnt),
        .cnt_clr   (cnt_clr)
    );

    typedef struct {
        logic [2*W-1:0]   n_rec;
        logic [2*W-1:0]   err;
        logic             mm;
        logic             dz;
        logic [CNT_W-1:0] cnt;
        int               acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    bit   seen    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: samples just after the falling edge, pops on a completed handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: got n_rec %0h expected no result", n_rec);
                end else begin
                    e = sb[0];
                    if (!seen) check("latency", cyc - e.acc_cyc, LAT);
                    seen = 1;
                    check("n_rec",    n_rec,    e.n_rec);
                    check("err",      err,      e.err);
                    check("mismatch", mismatch, e.mm);
                    check("dz",       dz,       e.dz);
                    check("mism_cnt", mism_cnt, e.cnt);
                    check("in_ready_in_done", in_ready, 0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [W-1:0] q_i, input logic [W-1:0] d_i, input logic [W-1:0] r_i,
                        input logic [2*W-1:0] nref_i, input logic [2*W-1:0] e_nrec,
                        input logic [2*W-1:0] e_err, input logic e_mm, input logic e_dz,
                        input logic [CNT_W-1:0] e_cnt, input bit push, input bit clr_fin);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1);
            return;
        end
        in_valid = 1'b1;
        q = q_i; d = d_i; r = r_i; n_ref = nref_i;
        if (push) sb.push_back('{e_nrec, e_err, e_mm, e_dz, e_cnt, cyc + 1});
        @(posedge clk);
        @(negedge clk);
        // Scramble the operand inputs while the multiply runs; they must be ignored.
        in_valid = 1'b0;
        q = W'($urandom); d = W'($urandom); r = W'($urandom); n_ref = (2*W)'($urandom);
        if (clr_fin) begin
            repeat (8) @(negedge clk);
            cnt_clr = 1'b1;
            @(negedge clk);
            cnt_clr = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
            seen = 0;
        end
    endtask

    initial begin
        int t;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        q = '0; d = '0; r = '0; n_ref = '0;
        #23;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_n_rec",     n_rec,     0);
        check("rst_err",       err,       0);
        check("rst_mismatch",  mismatch,  0);
        check("rst_dz",        dz,        0);
        check("rst_mism_cnt",  mism_cnt,  0);
        @(negedge clk);
        rst_n = 1'b1;

        // q, d, r, n_ref | n_rec, err, mismatch, dz, mism_cnt
        send(8'h0A, 8'h07, 8'h03, 16'h0049, 16'h0049, 16'h0000, 0, 0, 2'd0, 1, 0); drain();
        send(8'hFF, 8'hFF, 8'hFF, 16'hFF00, 16'hFF00, 16'h0000, 0, 0, 2'd0, 1, 0); drain();
        send(8'h05, 8'h0A, 8'h02, 16'h003C, 16'h0034, 16'h0008, 1, 0, 2'd1, 1, 0); drain();
        send(8'h05, 8'h0A, 8'h02, 16'h0030, 16'h0034, 16'h0004, 1, 0, 2'd2, 1, 0); drain();

        // Backpressure: hold the result, poke in_valid while in DONE.
        out_ready = 1'b0;
        send(8'h03, 8'h11, 8'h01, 16'h0034, 16'h0034, 16'h0000, 0, 0, 2'd2, 1, 0);
        t = 0;
        while (!out_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid", out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1;
            q = W'($urandom); d = W'($urandom); r = W'($urandom);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        send(8'h12, 8'h00, 8'h05, 16'h0005, 16'h0005, 16'h0000, 0, 1, 2'd2, 1, 0); drain();

        // Reset in the 4th cycle after accept; the request is discarded.
        send(8'h33, 8'h44, 8'h55, 16'h1234, 16'h0000, 16'h0000, 0, 0, 2'd0, 0, 0);
        repeat (3) @(posedge clk);
        check("mid_mul_in_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready",  in_ready,  1);
        check("mid_rst_mism_cnt",  mism_cnt,  0);
        check("mid_rst_n_rec",     n_rec,     0);
        @(negedge clk);
        rst_n = 1'b1;

        send(8'h81, 8'h02, 8'h01, 16'h0103, 16'h0103, 16'h0000, 0, 0, 2'd0, 1, 0); drain();

        // Four mismatches against a 2-bit counter: saturates at 3.
        send(8'h01, 8'h01, 8'h00, 16'h0010, 16'h0001, 16'h000F, 1, 0, 2'd1, 1, 0); drain();
        send(8'h01, 8'h01, 8'h00, 16'h0020, 16'h0001, 16'h001F, 1, 0, 2'd2, 1, 0); drain();
        send(8'h01, 8'h01, 8'h00, 16'h0000, 16'h0001, 16'h0001, 1, 0, 2'd3, 1, 0); drain();
        send(8'h01, 8'h01, 8'h00, 16'hFFFF, 16'h0001, 16'hFFFE, 1, 0, 2'd3, 1, 0); drain();

        // Clear lands on the same edge as a mismatching FIN: clear wins.
        send(8'h02, 8'h03, 8'h01, 16'h0009, 16'h0007, 16'h0002, 1, 0, 2'd0, 1, 1); drain();
        send(8'h10, 8'h10, 8'h00, 16'h0000, 16'h0100, 16'h0100, 1, 0, 2'd1, 1, 0); drain();

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/divider_array_reconstructor_seq.md
Name: divider_array_reconstructor_seq

Overview:
- Sequential inverse of the 16/8 array divider family: takes a divider result (q, r) with its divisor d and rebuilds the dividend as n_rec = q*d + r, using an iterative shift-add multiplier.
- Compares n_rec against the original dividend n_ref and reports absolute error plus a saturating mismatch count.
- Sits beside the exact and approximate divider rows in the error-characterisation harness, so approximate dividers can be scored on-chip.

Parameters:
- W, 8, divisor/quotient/remainder width; dividend, n_rec and err widths are 2*W.
- CNT_W, 16, width of the saturating mismatch counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- q  input  W  quotient under test.
- r  input  W  remainder under test.
- d  input  W  divisor.
- n_ref  input  2W  original dividend.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- n_rec  output  2W  reconstructed dividend q*d+r.
- err  output  2W  |n_ref - n_rec|.
- mismatch  output  1  err != 0.
- dz  output  1  captured d was zero.
- mism_cnt  output  CNT_W  saturating count of mismatching results.
- cnt_clr  input  1  synchronous clear of mism_cnt.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, n_rec=0, err=0, mismatch=0, dz=0, mism_cnt=0, all internal registers=0. Applies immediately, including mid-operation; any in-flight request is discarded.
- States: IDLE, MUL, FIN, DONE. in_ready = (state==IDLE), combinational from state. out_valid = (state==DONE).
- IDLE: on in_valid&in_ready at edge k, capture q, d, n_ref; set acc=zero-extended r, dz=(d==0), bit index i=0, go to MUL.
- MUL: on each edge, if q[i]=1 then acc += (d << i), computed in 2W bits; then i++. After the edge that processes i=W-1 (edge k+W), go to FIN.
- Accumulator width: the maximum result is (2^W-1)^2 + 2^W-1 = 2^2W - 2^W, so acc never overflows 2W bits and no carry-out is kept.
- FIN, edge k+W+1:
  - n_rec=acc.
  - err = n_ref>=acc ? n_ref-acc : acc-n_ref.
  - mismatch=(err!=0).
  - If mismatch and mism_cnt != all-ones, mism_cnt++.
  - Go to DONE.
- Latency: out_valid rises W+1 cycles after the accept edge (9 cycles for W=8). Throughput is one request per W+3 cycles at most.
- DONE: n_rec, err, mismatch and dz stay stable while out_valid=1 and out_ready=0. On the out_valid&out_ready edge, go to IDLE. in_ready stays 0 for that whole cycle, so no accept can coincide with the output handshake.
- Output registers keep their last values in IDLE and MUL; only out_valid qualifies them.
- d=0: no special datapath; result is n_rec=r, and dz=1 is reported.
- Inputs q, r, d and n_ref are ignored outside the accept cycle; changing them during MUL has no effect.
- cnt_clr: synchronous, works in any state. If cnt_clr and an increment land on the same edge, clear wins (result 0).
- mism_cnt saturates at 2^CNT_W-1.
- Fully synchronous to clk apart from rst_n. No combinational path from any input to any output.

Test Plan:
- Exact case: q=0x0A, d=0x07, r=0x03, n_ref=0x0049 → out_valid 9 cycles after accept; n_rec=0x0049, err=0, mismatch=0, mism_cnt unchanged.
- Max operands: q=0xFF, d=0xFF, r=0xFF, n_ref=0xFF00 → n_rec=0xFF00, err=0, no overflow.
- Mismatch: q=0x05, d=0x0A, r=0x02, n_ref=0x003C → n_rec=0x0034, err=0x0008, mismatch=1, mism_cnt 0→1. Repeat with n_ref=0x0030 → err=0x0004, mism_cnt=2.
- Backpressure and d=0:
  - Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0 throughout, in_valid pulses ignored.
  - Next request q=0x12, d=0x00, r=0x05, n_ref=0x0005 → n_rec=0x0005, dz=1, err=0.
- Reset mid-MUL: assert rst_n=0 at the 4th cycle after accept → out_valid=0, mism_cnt=0 and in_ready=1 immediately. After release, a fresh request completes normally in 9 cycles.
- Saturation and clear:
  - Force 2^CNT_W-1 mismatches (or use CNT_W=2 with 4 mismatches) → mism_cnt holds 3.
  - cnt_clr pulsed on the same edge as a mismatch FIN → mism_cnt=0.
